// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer:
// opcodes, FSM states and datapath mux selects.
package mc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_SLL  = 2'b10;
  localparam logic [1:0] ALU_OP_ADDI = 2'b11;

  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  localparam logic [1:0] ALUB_RT  = 2'b00;
  localparam logic [1:0] ALUB_ONE = 2'b01;
  localparam logic [1:0] ALUB_IMM = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; flags when the count
// has reached the timeout limit (limit 0 = never).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_mem_ready,
  output logic o_timeout
);

  localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);

  logic [TW-1:0] r_count;

  // Saturate so a disabled timeout never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !i_mem_ready && r_count != '1) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_timeout = (MEM_TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencing the shared 16-bit datapath
// through FETCH/DECODE/EXEC/MEM/WB with a memory timeout.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TW          = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic [2:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic [1:0] o_wb_sel,
  output logic       o_instr_done,
  output logic       o_fault,
  output logic [2:0] o_state_dbg
);

  state_e     r_state;
  state_e     w_next;
  logic [2:0] r_opcode;
  logic       w_timeout;
  logic       w_clear;
  logic       w_req;

  assign w_clear = (w_next != r_state);
  assign w_req   = o_mem_read | o_mem_write;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_clear),
    .i_enable   (w_req),
    .i_mem_ready(i_mem_ready),
    .o_timeout  (w_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_FETCH;
      r_opcode <= OP_ADD;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_opcode <= i_opcode;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = PC_SRC_INC;
    o_alu_src_b  = ALUB_RT;
    o_alu_op     = ALU_OP_ADD;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_wb_sel     = WB_ALU;
    o_instr_done = 1'b0;
    o_fault      = 1'b0;
    o_state_dbg  = r_state;

    case (r_state)
      ST_FETCH: begin
        if (i_run) begin
          o_mem_read = 1'b1;
          if (i_mem_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            w_next     = ST_DECODE;
          end else if (w_timeout) begin
            w_next = ST_FAULT;
          end
        end
      end
      // j/jal decide on the live IR; opcode_q is not valid yet.
      ST_DECODE: begin
        case (i_opcode)
          OP_J: begin
            o_pc_write   = 1'b1;
            o_pc_src     = PC_SRC_JMP;
            o_instr_done = 1'b1;
            w_next       = ST_FETCH;
          end
          OP_JAL: begin
            o_pc_write   = 1'b1;
            o_pc_src     = PC_SRC_JMP;
            o_reg_write  = 1'b1;
            o_wb_sel     = WB_PC;
            o_instr_done = 1'b1;
            w_next       = ST_FETCH;
          end
          default: w_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (r_opcode)
          OP_ADD: begin
            w_next = ST_WB;
          end
          OP_SLI: begin
            o_alu_src_b = ALUB_IMM;
            o_alu_op    = ALU_OP_SLL;
            w_next      = ST_WB;
          end
          OP_ADDI: begin
            o_alu_src_b = ALUB_IMM;
            o_alu_op    = ALU_OP_ADDI;
            w_next      = ST_WB;
          end
          OP_LW, OP_SW: begin
            o_alu_src_b = ALUB_IMM;
            o_alu_op    = ALU_OP_ADDI;
            w_next      = ST_MEM;
          end
          OP_BEQ: begin
            o_alu_op     = ALU_OP_SUB;
            o_pc_src     = PC_SRC_BR;
            o_pc_write   = i_zero;
            o_instr_done = 1'b1;
            w_next       = ST_FETCH;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        o_iord      = 1'b1;
        o_mem_read  = (r_opcode == OP_LW);
        o_mem_write = (r_opcode != OP_LW);
        if (i_mem_ready) begin
          if (r_opcode == OP_LW) begin
            w_next = ST_WB;
          end else begin
            o_instr_done = 1'b1;
            w_next       = ST_FETCH;
          end
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end
      end
      ST_WB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
        o_reg_dst    = (r_opcode == OP_ADD);
        o_wb_sel     = (r_opcode == OP_LW) ? WB_MEM : WB_ALU;
        w_next       = ST_FETCH;
      end
      ST_FAULT: begin
        o_fault = 1'b1;
      end
      default: w_next = ST_FETCH;
    endcase

    if (i_reset) begin
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 2'b00;
      o_alu_src_b  = 2'b00;
      o_alu_op     = 2'b00;
      o_reg_write  = 1'b0;
      o_reg_dst    = 1'b0;
      o_wb_sel     = 2'b00;
      o_instr_done = 1'b0;
      o_fault      = 1'b0;
      o_state_dbg  = 3'd0;
    end
  end

endmodule
